keycode_event_tracker: RTL and testbench

KEYCODE_EVENT_TRACKER -- requirements
Module: keycode_event_tracker

---
 rtl/keycode_pkg.sv | 33 +++
 rtl/event_fifo.sv | 57 +++++
 rtl/keycode_event_tracker.sv | 118 +++++++++++
 tb/tb_keycode_event_tracker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keycode_pkg.sv
// Shared constants, FSM state type and helpers for the keycode event tracker.
package keycode_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int FIFO_DEPTH    = 8;
    localparam int EVT_W         = 9;
    localparam int EVT_PRESS_BIT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN0 = 3'd1,
        SCAN1 = 3'd2,
        SCAN2 = 3'd3,
        SCAN3 = 3'd4
    } scan_state_t;

    // True when code sits in either 8-bit slot of a 16-bit keycode pair.
    function automatic logic in_pair(input logic [7:0] code, input logic [15:0] pair);
        return (code == pair[7:0]) || (code == pair[15:8]);
    endfunction

    // Held-key mask of a keycode pair: {Space, D, S, A, W}.
    function automatic logic [4:0] key_mask(input logic [15:0] pair);
        return {in_pair(KEY_SPACE, pair), in_pair(KEY_D, pair), in_pair(KEY_S, pair),
                in_pair(KEY_A, pair), in_pair(KEY_W, pair)};
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds only when a pop
// happens on the same edge.
module event_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    // The head reads as zero while empty so the output is defined during reset.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage write.
    // NOTE: the array has no reset; every entry is written before it can be read, and empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keycode_event_tracker.sv
// Turns snapshots of two HID keycode slots into press/release events, queued in
// a FIFO, plus a held-key mask for the WASD/Space keys.
module keycode_event_tracker
    import keycode_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      keycode_in,
    input  logic             evt_ready,
    input  logic             clear_overflow,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_data,
    output logic [4:0]       held_mask,
    output logic             overflow
);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [15:0]      kc_q;
    logic [15:0]      kc_prev;
    logic [15:0]      snap_old;
    logic [15:0]      snap_new;
    logic             push;
    logic [EVT_W-1:0] push_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             start_scan;

    assign start_scan = (state == IDLE) && (kc_q != kc_prev);
    assign evt_valid  = !fifo_empty;
    assign pop        = evt_valid && evt_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and the single candidate event each scan step may push.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_data  = '0;
        case (state)
            IDLE: begin
                if (start_scan) state_next = SCAN0;
            end
            SCAN0: begin
                push_data[7:0] = snap_old[7:0];
                push           = (snap_old[7:0] != 8'h00) && !in_pair(snap_old[7:0], snap_new);
                state_next     = SCAN1;
            end
            SCAN1: begin
                push_data[7:0] = snap_old[15:8];
                push           = (snap_old[15:8] != 8'h00) && !in_pair(snap_old[15:8], snap_new)
                                 && (snap_old[15:8] != snap_old[7:0]);
                state_next     = SCAN2;
            end
            SCAN2: begin
                push_data[EVT_PRESS_BIT] = 1'b1;
                push_data[7:0]           = snap_new[7:0];
                push       = (snap_new[7:0] != 8'h00) && !in_pair(snap_new[7:0], snap_old);
                state_next = SCAN3;
            end
            SCAN3: begin
                push_data[EVT_PRESS_BIT] = 1'b1;
                push_data[7:0]           = snap_new[15:8];
                push       = (snap_new[15:8] != 8'h00) && !in_pair(snap_new[15:8], snap_old)
                             && (snap_new[15:8] != snap_new[7:0]);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Input register, snapshots taken at scan start, and the held mask tracking kc_prev.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q      <= '0;
            kc_prev   <= '0;
            snap_old  <= '0;
            snap_new  <= '0;
            held_mask <= '0;
        end else begin
            kc_q <= keycode_in;
            if (start_scan) begin
                snap_old  <= kc_prev;
                snap_new  <= kc_q;
                kc_prev   <= kc_q;
                held_mask <= key_mask(kc_q);
            end
        end
    end

    // Sticky overflow: a dropped push sets it, and wins over a coinciding clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      overflow <= 1'b0;
        else if (push && fifo_full && !pop) overflow <= 1'b1;
        else if (clear_overflow)           overflow <= 1'b0;
    end

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_keycode_event_tracker.sv
// Bench for keycode_event_tracker: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a set-difference model.
module tb_keycode_event_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] keycode_in;
    logic        evt_ready;
    logic        clear_overflow;
    logic        evt_valid;
    logic [8:0]  evt_data;
    logic [4:0]  held_mask;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keycode_event_tracker dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .keycode_in     (keycode_in),
        .evt_ready      (evt_ready),
        .clear_overflow (clear_overflow),
        .evt_valid      (evt_valid),
        .evt_data       (evt_data),
        .held_mask      (held_mask),
        .overflow       (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0]  mq[$];       // queued events, head first
    logic [15:0] m_kc_q;
    logic [15:0] m_prev;
    int          m_scan;      // -1 idle, else slot index 0..3 being examined
    logic [9:0]  m_plan[4];   // {valid, press, code} per scan slot
    logic        m_ovf;

    function automatic logic has(input logic [15:0] p, input logic [7:0] c);
        return (c == p[7:0]) || (c == p[15:8]);
    endfunction

    function automatic logic [4:0] mask_of(input logic [15:0] p);
        logic [7:0] keys[5] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C};
        logic [4:0] m;
        for (int i = 0; i < 5; i++) m[i] = has(p, keys[i]);
        return m;
    endfunction

    task automatic build_plan(input logic [15:0] o, input logic [15:0] n);
        m_plan[0] = {(o[7:0]  != 0) && !has(n, o[7:0]), 1'b0, o[7:0]};
        m_plan[1] = {(o[15:8] != 0) && !has(n, o[15:8]) && (o[15:8] != o[7:0]), 1'b0, o[15:8]};
        m_plan[2] = {(n[7:0]  != 0) && !has(o, n[7:0]), 1'b1, n[7:0]};
        m_plan[3] = {(n[15:8] != 0) && !has(o, n[15:8]) && (n[15:8] != n[7:0]), 1'b1, n[15:8]};
    endtask

    task automatic model_reset();
        mq.delete();
        m_kc_q = '0;
        m_prev = '0;
        m_scan = -1;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        bit pop;
        bit set;
        pop = (mq.size() > 0) && evt_ready;
        set = 1'b0;
        if (pop) void'(mq.pop_front());
        if (m_scan >= 0 && m_plan[m_scan][9]) begin
            if (mq.size() < 8) mq.push_back(m_plan[m_scan][8:0]);
            else               set = 1'b1;
        end
        if (set)                 m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
        if (m_scan >= 0) begin
            m_scan = (m_scan == 3) ? -1 : m_scan + 1;
        end else if (m_kc_q != m_prev) begin
            build_plan(m_prev, m_kc_q);
            m_prev = m_kc_q;
            m_scan = 0;
        end
        m_kc_q = keycode_in;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("evt_valid", evt_valid, mq.size() != 0);
            check("evt_data", evt_data, (mq.size() != 0) ? mq[0] : 9'h000);
            check("held_mask", held_mask, mask_of(m_prev));
            check("overflow", overflow, m_ovf);
        end
    end

    // Log of events the DUT hands over, for the literal directed checks.
    logic [8:0] log_q[$];
    always @(posedge clk) begin
        if (reset_n && evt_valid && evt_ready) log_q.push_back(evt_data);
    end

    // Advance n falling edges, then settle 1 time unit before driving.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    logic [7:0] pool[7] = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h05};

    initial begin
        reset_n        = 1'b0;
        keycode_in     = '0;
        evt_ready      = 1'b0;
        clear_overflow = 1'b0;
        cyc(2);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_data", evt_data, 9'h000);
        check("rst_held", held_mask, 5'b00000);
        check("rst_ovf", overflow, 1'b0);
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        cyc(3);

        // Single press of W from empty; press appears after the SCAN2 edge (k+4).
        log_q.delete();
        keycode_in = 16'h001A;
        cyc(2);
        check("w_held", held_mask, 5'b00001);
        check("w_early", evt_valid, 1'b0);
        cyc(2);
        check("w_k3", evt_valid, 1'b0);
        cyc(1);
        check("w_k4_valid", evt_valid, 1'b1);
        check("w_k4_data", evt_data, 9'h11A);
        cyc(6);
        check("w_count", log_q.size(), 1);
        check("w_evt", log_q[0], 9'h11A);

        // W -> A+D: release first (after k+2), presses in slot order, last after k+5.
        log_q.delete();
        keycode_in = 16'h0704;
        cyc(3);
        check("ad_first_valid", evt_valid, 1'b1);
        check("ad_first_data", evt_data, 9'h01A);
        cyc(3);
        check("ad_last_data", evt_data, 9'h107);
        cyc(5);
        check("ad_count", log_q.size(), 3);
        check("ad_e0", log_q[0], 9'h01A);
        check("ad_e1", log_q[1], 9'h104);
        check("ad_e2", log_q[2], 9'h107);
        check("ad_held", held_mask, 5'b01010);

        // Same key in both slots reports once.
        keycode_in = 16'h0000;
        cyc(8);
        log_q.delete();
        keycode_in = 16'h0404;
        cyc(8);
        check("dup_count", log_q.size(), 1);
        check("dup_evt", log_q[0], 9'h104);
        check("dup_held", held_mask, 5'b00010);

        // Overflow: nine Space toggles with the consumer stalled.
        keycode_in = 16'h0000;
        cyc(8);
        evt_ready = 1'b0;
        log_q.delete();
        for (int i = 0; i < 9; i++) begin
            keycode_in = (i % 2 == 0) ? 16'h002C : 16'h0000;
            cyc(6);
            if (i == 7) check("ovf_before", overflow, 1'b0);
        end
        check("ovf_set", overflow, 1'b1);
        check("ovf_head", evt_data, 9'h12C);
        evt_ready = 1'b1;
        cyc(10);
        check("ovf_drain_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check("ovf_drain_evt", log_q[i], (i % 2 == 0) ? 9'h12C : 9'h02C);
        check("ovf_sticky", overflow, 1'b1);
        clear_overflow = 1'b1;
        cyc(1);
        clear_overflow = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        check("space_held", held_mask, 5'b10000);

        // Full FIFO, then push and pop on the same edge.
        keycode_in = 16'h0000;
        cyc(8);
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            keycode_in = (i % 2 == 0) ? 16'h002C : 16'h0000;
            cyc(6);
        end
        log_q.delete();
        keycode_in = 16'h002C;
        cyc(4);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        check("pp_ovf", overflow, 1'b0);
        check("pp_head", evt_data, 9'h02C);
        evt_ready = 1'b1;
        cyc(10);
        check("pp_count", log_q.size(), 9);
        check("pp_e1", log_q[1], 9'h02C);
        check("pp_last", log_q[8], 9'h12C);
        check("pp_ovf_end", overflow, 1'b0);

        // Reset in SCAN1 with three events queued.
        evt_ready = 1'b0;
        keycode_in = 16'h0000;
        cyc(6);
        keycode_in = 16'h002C;
        cyc(6);
        keycode_in = 16'h0016;
        cyc(3);
        check("rs_pre_valid", evt_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rs_valid", evt_valid, 1'b0);
        check("rs_data", evt_data, 9'h000);
        cyc(2);
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        log_q.delete();
        cyc(10);
        check("rs_count", log_q.size(), 1);
        check("rs_evt", log_q[0], 9'h116);
        check("rs_held", held_mask, 5'b00100);

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 4) == 0)
                keycode_in = {pool[$urandom_range(0, 6)], pool[$urandom_range(0, 6)]};
            if ((c / 400) % 2 == 1) evt_ready = ($urandom_range(0, 9) == 0);
            else                    evt_ready = ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 599) == 0) reset_n = 1'b0;
            else                             reset_n = 1'b1;
            cyc(1);
        end
        reset_n = 1'b1;
        cyc(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
